// File: rtl/wallace_mac_accumulator_if.sv
// wallace_mac_accumulator_if: product input, flush and frame-result handshake bundle
interface wallace_mac_accumulator_if #(parameter int PROD_W = 8, parameter int ACC_W = 16);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;
    logic [7:0]        count;
    modport master (
        output flush, in_valid, prod, out_ready,
        input  in_ready, out_valid, acc_out, overflow, count
    );
    modport slave (
        input  flush, in_valid, prod, out_ready,
        output in_ready, out_valid, acc_out, overflow, count
    );
endinterface

// File: rtl/wallace_mac_accumulator.sv
// wallace_mac_accumulator: LEN-product dot-product accumulator; WALLACE_MAC_SATURATE_EN clamps instead of wrapping
module wallace_mac_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN    = 4
) (
    input logic clk,
    input logic rst,
    wallace_mac_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_q, out_d, acc_nx;
    logic [ACC_W:0]   sum;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d;
    always_comb begin
        sum = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, bus.prod};
`ifdef WALLACE_MAC_SATURATE_EN
        acc_nx = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nx = sum[ACC_W-1:0];
`endif
        cnt_inc = cnt_q + 8'd1;
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (state_q == ACCUM) begin
            if (bus.flush) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (bus.in_valid) begin
                acc_d = acc_nx;
                ovf_d = ovf_q | sum[ACC_W];
                cnt_d = cnt_inc;
                if (cnt_inc == 8'(LEN)) begin
                    out_d   = acc_nx;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
        end else if (bus.out_ready) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.in_ready  = state_q == ACCUM;
    assign bus.out_valid = state_q == HOLD;
    assign bus.acc_out   = out_q;
    assign bus.overflow  = ovf_q;
    assign bus.count     = cnt_q;
endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// tb_wallace_mac_accumulator: scoreboard bench for a 16-bit and a 9-bit accumulator instance
module tb_wallace_mac_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    bit done_b = 1'b0;
    logic [16:0] qa[$];
    logic [9:0]  qb[$];
`ifdef WALLACE_MAC_SATURATE_EN
    localparam logic [8:0] OVF_EXP = 9'd511;
`else
    localparam logic [8:0] OVF_EXP = 9'd388;
`endif
    wallace_mac_accumulator_if #(.PROD_W(8), .ACC_W(16)) ba();
    wallace_mac_accumulator_if #(.PROD_W(8), .ACC_W(9))  bb();
    wallace_mac_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    wallace_mac_accumulator #(.PROD_W(8), .ACC_W(9),  .LEN(4)) dut_b (.clk(clk), .rst(rst), .bus(bb));

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic drv_a(input logic v, input logic [7:0] p, input logic f, input logic r);
        @(posedge clk);
        #1;
        ba.in_valid = v; ba.prod = p; ba.flush = f; ba.out_ready = r;
    endtask

    task automatic drv_b(input logic v, input logic [7:0] p, input logic r);
        @(posedge clk);
        #1;
        bb.in_valid = v; bb.prod = p; bb.flush = 1'b0; bb.out_ready = r;
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && ba.out_valid && ba.out_ready) begin
            if (qa.size() == 0) chk("mon_a_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                chk("mon_a_acc", 32'(ba.acc_out), 32'(e[15:0]));
                chk("mon_a_ovf", 32'(ba.overflow), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && bb.out_valid && bb.out_ready) begin
            if (qb.size() == 0) chk("mon_b_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                chk("mon_b_acc", 32'(bb.acc_out), 32'(e[8:0]));
                chk("mon_b_ovf", 32'(bb.overflow), 32'(e[9]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ba.in_valid = 1'b1; ba.prod = 8'hFF; ba.flush = 1'b0; ba.out_ready = 1'b1;
        bb.in_valid = 1'b1; bb.prod = 8'hFF; bb.flush = 1'b0; bb.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ba.in_valid = 1'b0;
        bb.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(ba.out_valid), 0);
        chk("rst_overflow", 32'(ba.overflow), 0);
        chk("rst_count", 32'(ba.count), 0);
        chk("rst_in_ready", 32'(ba.in_ready), 1);
        chk("rst_acc_out", 32'(ba.acc_out), 0);
        // basic frame: 225 x4, result one cycle after the last product
        qa.push_back({1'b0, 16'd900});
        repeat (4) drv_a(1, 8'd225, 0, 1);
        drv_a(0, 0, 0, 1);
        @(negedge clk);
        chk("basic_latency", 32'(ba.out_valid), 1);
        chk("basic_acc", 32'(ba.acc_out), 900);
        @(negedge clk);
        chk("basic_in_ready", 32'(ba.in_ready), 1);
        chk("basic_count", 32'(ba.count), 0);
        chk("basic_out_valid_clr", 32'(ba.out_valid), 0);
        // backpressure: 1..4 then hold with 9 pending
        qa.push_back({1'b0, 16'd10});
        for (int i = 1; i <= 4; i++) drv_a(1, 8'(i), 0, 0);
        drv_a(1, 8'd9, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_acc_hold", 32'(ba.acc_out), 10);
            chk("bp_in_ready", 32'(ba.in_ready), 0);
            chk("bp_out_valid", 32'(ba.out_valid), 1);
        end
        drv_a(1, 8'd9, 0, 1);
        drv_a(1, 8'd9, 0, 1);
        qa.push_back({1'b0, 16'd12});
        drv_a(1, 8'd1, 0, 1);
        @(negedge clk);
        chk("bp_next_count", 32'(ba.count), 1);
        drv_a(1, 8'd1, 0, 1);
        drv_a(1, 8'd1, 0, 1);
        drv_a(0, 0, 0, 1);
        // flush in ACCUM drops partial frame and the product offered with it
        qa.push_back({1'b0, 16'd4});
        drv_a(1, 8'd100, 0, 1);
        drv_a(1, 8'd50, 0, 1);
        drv_a(1, 8'd7, 1, 1);
        @(negedge clk);
        chk("flush_pre_count", 32'(ba.count), 2);
        drv_a(1, 8'd1, 0, 1);
        @(negedge clk);
        chk("flush_post_count", 32'(ba.count), 0);
        repeat (3) drv_a(1, 8'd1, 0, 1);
        drv_a(0, 0, 0, 1);
        @(negedge clk);
        chk("flush_out_valid", 32'(ba.out_valid), 1);
        chk("flush_acc", 32'(ba.acc_out), 4);
        // flush in HOLD is ignored
        qa.push_back({1'b0, 16'd8});
        drv_a(1, 8'd2, 0, 1);
        repeat (3) drv_a(1, 8'd2, 0, 0);
        drv_a(0, 0, 1, 0);
        drv_a(0, 0, 0, 0);
        @(negedge clk);
        chk("hold_flush_valid", 32'(ba.out_valid), 1);
        chk("hold_flush_acc", 32'(ba.acc_out), 8);
        chk("hold_flush_in_ready", 32'(ba.in_ready), 0);
        drv_a(0, 0, 0, 1);
        drv_a(0, 0, 0, 0);
        @(negedge clk);
        chk("post_hs_valid", 32'(ba.out_valid), 0);
        chk("post_hs_acc_kept", 32'(ba.acc_out), 8);
        wait (done_b);
        chk("drain_a", 32'(qa.size()), 0);
        chk("drain_b", 32'(qb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        wait (rst == 1'b0);
        // 9-bit accumulator: 900 overflows
        qb.push_back({1'b1, OVF_EXP});
        repeat (4) drv_b(1, 8'd225, 1);
        drv_b(0, 0, 1);
        @(negedge clk);
        chk("ovf_set", 32'(bb.overflow), 1);
        @(negedge clk);
        chk("ovf_clear", 32'(bb.overflow), 0);
        qb.push_back({1'b0, 9'd10});
        for (int i = 1; i <= 4; i++) drv_b(1, 8'(i), 1);
        drv_b(0, 0, 1);
        drv_b(0, 0, 1);
        @(negedge clk);
        done_b = 1'b1;
    end
endmodule
